uart_tx_arb: RTL

- Round-robin arbiter and sequencer that shares one uartTX_top instance between NUM_REQ byte producers, e.g. register-file readback, ALU result and status reporter.
- Samples requests, latches the winner's byte and pulses the UART's one-cycle data_valid.
- Tracks the UART busy flag through the whole frame, then enforces an optional inter-frame gap before the next grant.
- Sits directly in front of uartTX_top; its outputs drive p_data/data_valid, and its tx_busy input is the UART's busy.

---
 rtl/uart_tx_arb.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin front end that lets NUM_REQ byte producers share one UART transmitter.
// It latches the winning byte, launches it, follows the UART busy flag and then applies an optional idle gap.
module uart_tx_arb #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               gnt,
  input  logic                             tx_busy,
  output logic [DATA_WIDTH-1:0]            tx_p_data,
  output logic                             tx_data_valid,
  output logic [$clog2(NUM_REQ)-1:0]       active_id,
  output logic                             arb_idle,
  output logic                             err_timeout,
  output logic [2:0]                       dbg_state
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam int GP_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_e;

  // Handshake: req[i] is a level held with its byte until gnt[i] pulses for one
  // cycle; that pulse coincides with tx_data_valid, which the UART treats as a
  // single-cycle launch strobe while tx_p_data is stable from then on.

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  dv_q, dv_d;
  logic [IDW-1:0]        id_q, id_d;
  logic [IDW-1:0]        last_q, last_d;
  logic                  err_q, err_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [GP_W-1:0]       gap_cnt_q, gap_cnt_d;

  logic                  win_found;
  logic [IDW-1:0]        win_idx;

  // Scan starts just after the last winner so the previous owner ranks lowest.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req[IDW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    dv_d      = 1'b0;
    err_d     = 1'b0;
    pdata_d   = pdata_q;
    id_d      = id_q;
    last_d    = last_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found && !tx_busy) begin
          state_d        = S_LAUNCH;
          pdata_d        = req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          dv_d           = 1'b1;
          gnt_d[win_idx] = 1'b1;
          id_d           = win_idx;
          last_d         = win_idx;
        end
      end
      S_LAUNCH: begin
        state_d  = S_WAIT_BUSY;
        to_cnt_d = '0;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
          // UART never acknowledged the launch; the byte is dropped.
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (GAP_CYCLES > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GP_W'(GAP_CYCLES - 1)) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      pdata_q   <= '0;
      dv_q      <= 1'b0;
      id_q      <= '0;
      last_q    <= IDW'(NUM_REQ - 1);
      err_q     <= 1'b0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      pdata_q   <= pdata_d;
      dv_q      <= dv_d;
      id_q      <= id_d;
      last_q    <= last_d;
      err_q     <= err_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign gnt           = gnt_q;
  assign tx_p_data     = pdata_q;
  assign tx_data_valid = dv_q;
  assign active_id     = id_q;
  assign err_timeout   = err_q;
  assign arb_idle      = (state_q == S_IDLE);
  assign dbg_state     = state_q;

endmodule
